// File: rtl/counter_vector_engine.sv
// counter_vector_engine: self-test producer/checker for the N-bit universal counter.
// Generates a reproducible stream of control/parallel-in vectors from a 32-bit
// Galois LFSR, drives them into the counter, keeps a golden model of the count,
// and compares the counter's count against the model every cycle after a vector.
// Optional build macro: CORNER_PREAMBLE_EN adds four directed wrap-around vectors
// (load all-ones, up, down, hold) ahead of the random vectors.
module counter_vector_engine #(
    parameter int          N           = 16,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_2F5B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         dut_rst_n,
    output logic [1:0]   ctrl_out,
    output logic [N-1:0] pin_out,
    input  logic [N-1:0] count_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         mismatch,
    output logic [15:0]  error_count,
    output logic [15:0]  vector_count
);

`ifdef CORNER_PREAMBLE_EN
    localparam int PRE_LEN = 4;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int          RUN_LEN  = NUM_VECTORS + PRE_LEN;
    localparam logic [16:0] RUN_LAST = 17'(RUN_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DUTRST = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t         state_r;
    logic [31:0]    lfsr_r;
    logic [N-1:0]   model_r;
    logic [16:0]    run_idx_r;   // vectors presented so far; wider than vector_count
    logic           cmp_en_r;    // previous cycle was a RUN cycle
    logic           rst_cnt_r;   // second DUTRST cycle marker

    logic [1:0]     vec_ctrl_s;
    logic [N-1:0]   vec_pin_s;
    logic           vec_rand_s;
    logic           miss_s;
    logic [15:0]    err_next_s;

    // Galois right-shift step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Counter semantics: 00 hold, 01 up, 10 down, 11 load, all mod 2^N.
    function automatic logic [N-1:0] count_step(input logic [N-1:0] c,
                                                input logic [1:0]   op,
                                                input logic [N-1:0] p);
        logic [N-1:0] r;
        case (op)
            2'b01:   r = c + N'(1);
            2'b10:   r = c - N'(1);
            2'b11:   r = p;
            default: r = c;
        endcase
        return r;
    endfunction

    // Choose the vector for the next RUN cycle: directed preamble or LFSR bits.
    always_comb begin
        vec_ctrl_s = lfsr_r[1:0];
        vec_pin_s  = lfsr_r[N+1:2];
        vec_rand_s = 1'b1;
`ifdef CORNER_PREAMBLE_EN
        if (run_idx_r < 17'd4) begin
            vec_rand_s = 1'b0;
            vec_pin_s  = '0;
            case (run_idx_r[1:0])
                2'd0: begin
                    vec_ctrl_s = 2'b11;
                    vec_pin_s  = {N{1'b1}};
                end
                2'd1:    vec_ctrl_s = 2'b01;
                2'd2:    vec_ctrl_s = 2'b10;
                default: vec_ctrl_s = 2'b00;
            endcase
        end else begin
            vec_rand_s = 1'b1;
        end
`endif
    end

    // Compare the counter against the model and form the saturating error count.
    always_comb begin
        miss_s     = cmp_en_r && (count_in != model_r);
        err_next_s = error_count;
        if (miss_s && (error_count != 16'hFFFF)) begin
            err_next_s = error_count + 16'd1;
        end else begin
            err_next_s = error_count;
        end
    end

    // Run sequencer, vector generator, golden model and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            lfsr_r       <= SEED;
            model_r      <= '0;
            run_idx_r    <= 17'd0;
            cmp_en_r     <= 1'b0;
            rst_cnt_r    <= 1'b0;
            dut_rst_n    <= 1'b1;
            ctrl_out     <= 2'b00;
            pin_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch     <= 1'b0;
            error_count  <= 16'd0;
            vector_count <= 16'd0;
        end else begin
            mismatch    <= miss_s;
            error_count <= err_next_s;
            cmp_en_r    <= (state_r == RUN);
            if (state_r == RUN) begin
                model_r <= count_step(model_r, ctrl_out, pin_out);
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r      <= DUTRST;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        dut_rst_n    <= 1'b0;
                        ctrl_out     <= 2'b00;
                        pin_out      <= '0;
                        lfsr_r       <= SEED;
                        model_r      <= '0;
                        run_idx_r    <= 17'd0;
                        rst_cnt_r    <= 1'b0;
                        error_count  <= 16'd0;
                        vector_count <= 16'd0;
                    end
                end
                DUTRST: begin
                    model_r <= '0;
                    if (rst_cnt_r) begin
                        state_r   <= SETTLE;
                        dut_rst_n <= 1'b1;
                    end else begin
                        rst_cnt_r <= 1'b1;
                    end
                end
                SETTLE, RUN: begin
                    if ((state_r == RUN) && (run_idx_r == RUN_LAST)) begin
                        state_r  <= DRAIN;
                        ctrl_out <= 2'b00;
                        pin_out  <= '0;
                    end else begin
                        state_r   <= RUN;
                        ctrl_out  <= vec_ctrl_s;
                        pin_out   <= vec_pin_s;
                        run_idx_r <= run_idx_r + 17'd1;
                        if (vector_count != 16'hFFFF) begin
                            vector_count <= vector_count + 16'd1;
                        end
                        if (vec_rand_s) begin
                            lfsr_r <= lfsr_step(lfsr_r);
                        end
                    end
                end
                DRAIN: begin
                    state_r <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (err_next_s == 16'd0);
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    dut_rst_n <= 1'b1;
                    ctrl_out  <= 2'b00;
                    pin_out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_vector_engine.sv
// Directed bench for counter_vector_engine with a behavioural universal counter.
module tb_counter_vector_engine;

`ifdef CORNER_PREAMBLE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 0;
`endif
    localparam int NV       = 8;
    localparam int BUSY_EXP = NV + PRE + 4;

    logic        clk = 1'b0;
    logic        rst, start, rst2, start2;
    logic        zero_bit0;
    logic        dut_rst_n, busy, done, pass, mismatch;
    logic [1:0]  ctrl_out;
    logic [15:0] pin_out, count_in, error_count, vector_count, cnt;
    logic        dut_rst_n2, busy2, done2, pass2, mismatch2;
    logic [1:0]  ctrl_out2;
    logic [15:0] pin_out2, count_in2, error_count2, vector_count2, cnt2;

    int total = 0;
    int bad   = 0;

    int          busy_n, rstlow_n, miss_n;
    logic        got_done, first_busy;
    logic [1:0]  tr_ctrl [64];
    logic [15:0] tr_pin  [64];
    logic [15:0] tr_cnt  [64];
    logic [1:0]  ref_ctrl [64];
    logic [15:0] ref_pin  [64];

    always #5 clk = ~clk;

    counter_vector_engine #(.N(16), .NUM_VECTORS(NV), .SEED(32'hACE1_2F5B)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_rst_n(dut_rst_n),
        .ctrl_out(ctrl_out), .pin_out(pin_out), .count_in(count_in),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .error_count(error_count), .vector_count(vector_count)
    );

    counter_vector_engine #(.N(16), .NUM_VECTORS(65535), .SEED(32'hACE1_2F5B)) dut_sat (
        .clk(clk), .rst(rst2), .start(start2), .dut_rst_n(dut_rst_n2),
        .ctrl_out(ctrl_out2), .pin_out(pin_out2), .count_in(count_in2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
        .error_count(error_count2), .vector_count(vector_count2)
    );

    // Reference universal counter driven by the engine.
    always_ff @(posedge clk) begin
        if (!dut_rst_n) cnt <= 16'd0;
        else case (ctrl_out)
            2'b01:   cnt <= cnt + 16'd1;
            2'b10:   cnt <= cnt - 16'd1;
            2'b11:   cnt <= pin_out;
            default: cnt <= cnt;
        endcase
    end
    assign count_in = zero_bit0 ? {cnt[15:1], 1'b0} : cnt;

    // Second counter whose reported count is always inverted, so every compare fails.
    always_ff @(posedge clk) begin
        if (!dut_rst_n2) cnt2 <= 16'd0;
        else case (ctrl_out2)
            2'b01:   cnt2 <= cnt2 + 16'd1;
            2'b10:   cnt2 <= cnt2 - 16'd1;
            2'b11:   cnt2 <= pin_out2;
            default: cnt2 <= cnt2;
        endcase
    end
    assign count_in2 = ~cnt2;

    task automatic run_capture(input int inject_at);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; rstlow_n = 0; miss_n = 0; got_done = 1'b0;
        first_busy = busy;
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (mismatch) miss_n++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy && busy_n < 64) begin
                    tr_ctrl[busy_n] = ctrl_out;
                    tr_pin[busy_n]  = pin_out;
                    tr_cnt[busy_n]  = count_in;
                    busy_n++;
                end
                if (!dut_rst_n) rstlow_n++;
                start = (c == inject_at);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got %0h want 0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got %0h want 0", done); end
        total++; if (pass !== 1'b0)        begin bad++; $display("FAIL reset_pass got %0h want 0", pass); end
        total++; if (mismatch !== 1'b0)    begin bad++; $display("FAIL reset_mismatch got %0h want 0", mismatch); end
        total++; if (dut_rst_n !== 1'b1)   begin bad++; $display("FAIL reset_dut_rst_n got %0h want 1", dut_rst_n); end
        total++; if (ctrl_out !== 2'b00)   begin bad++; $display("FAIL reset_ctrl got %0h want 0", ctrl_out); end
        total++; if (pin_out !== 16'h0)    begin bad++; $display("FAIL reset_pin got %0h want 0", pin_out); end
        total++; if (error_count !== 16'h0) begin bad++; $display("FAIL reset_err got %0h want 0", error_count); end
        total++; if (vector_count !== 16'h0) begin bad++; $display("FAIL reset_vc got %0h want 0", vector_count); end
    endtask

    task automatic test_good_run();
        run_capture(-1);
        total++; if (got_done !== 1'b1) begin bad++; $display("FAIL good_timeout got %0h want 1", got_done); end
        total++; if (first_busy !== 1'b1) begin bad++; $display("FAIL good_first_busy got %0h want 1", first_busy); end
        total++; if (busy_n != BUSY_EXP) begin bad++; $display("FAIL good_busy_cycles got %0d want %0d", busy_n, BUSY_EXP); end
        total++; if (rstlow_n != 2) begin bad++; $display("FAIL good_rst_cycles got %0d want 2", rstlow_n); end
        total++; if (miss_n != 0) begin bad++; $display("FAIL good_mismatch got %0d want 0", miss_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_done got %0h want 0", busy); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL good_pass got %0h want 1", pass); end
        total++; if (error_count !== 16'h0) begin bad++; $display("FAIL good_err got %0h want 0", error_count); end
        total++; if (vector_count !== 16'(NV + PRE)) begin bad++; $display("FAIL good_vc got %0d want %0d", vector_count, NV + PRE); end
        total++; if (tr_ctrl[3+PRE] !== 2'b11) begin bad++; $display("FAIL vec0_ctrl got %0h want 3", tr_ctrl[3+PRE]); end
        total++; if (tr_pin[3+PRE] !== 16'h4BD6) begin bad++; $display("FAIL vec0_pin got %0h want 4bd6", tr_pin[3+PRE]); end
        total++; if (tr_ctrl[4+PRE] !== 2'b10) begin bad++; $display("FAIL vec1_ctrl got %0h want 2", tr_ctrl[4+PRE]); end
        total++; if (tr_pin[4+PRE] !== 16'h25EB) begin bad++; $display("FAIL vec1_pin got %0h want 25eb", tr_pin[4+PRE]); end
        for (int i = 0; i < 64; i++) begin
            ref_ctrl[i] = tr_ctrl[i];
            ref_pin[i]  = tr_pin[i];
        end
    endtask

`ifdef CORNER_PREAMBLE_EN
    task automatic test_preamble();
        logic [1:0]  exp_c [4];
        logic [15:0] exp_p [4];
        logic [15:0] exp_n [4];
        exp_c[0] = 2'b11; exp_c[1] = 2'b01; exp_c[2] = 2'b10; exp_c[3] = 2'b00;
        exp_p[0] = 16'hFFFF; exp_p[1] = 16'h0; exp_p[2] = 16'h0; exp_p[3] = 16'h0;
        exp_n[0] = 16'hFFFF; exp_n[1] = 16'h0; exp_n[2] = 16'hFFFF; exp_n[3] = 16'hFFFF;
        run_capture(-1);
        for (int i = 0; i < 4; i++) begin
            total++; if (tr_ctrl[3+i] !== exp_c[i]) begin bad++; $display("FAIL pre_ctrl%0d got %0h want %0h", i, tr_ctrl[3+i], exp_c[i]); end
            total++; if (tr_pin[3+i] !== exp_p[i]) begin bad++; $display("FAIL pre_pin%0d got %0h want %0h", i, tr_pin[3+i], exp_p[i]); end
            total++; if (tr_cnt[4+i] !== exp_n[i]) begin bad++; $display("FAIL pre_count%0d got %0h want %0h", i, tr_cnt[4+i], exp_n[i]); end
        end
        total++; if (miss_n != 0) begin bad++; $display("FAIL pre_mismatch got %0d want 0", miss_n); end
    endtask
`endif

    task automatic test_bad_counter();
        zero_bit0 = 1'b1;
        run_capture(-1);
        zero_bit0 = 1'b0;
        total++; if (got_done !== 1'b1) begin bad++; $display("FAIL bad_timeout got %0h want 1", got_done); end
        total++; if (miss_n == 0) begin bad++; $display("FAIL bad_pulses got %0d want >0", miss_n); end
        total++; if (error_count !== 16'(miss_n)) begin bad++; $display("FAIL bad_err got %0d want %0d", error_count, miss_n); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL bad_pass got %0h want 0", pass); end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got %0h want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %0h want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got %0h want 0", done); end
        total++; if (ctrl_out !== 2'b00) begin bad++; $display("FAIL midrst_ctrl got %0h want 0", ctrl_out); end
        total++; if (dut_rst_n !== 1'b1) begin bad++; $display("FAIL midrst_dut_rst_n got %0h want 1", dut_rst_n); end
        total++; if (error_count !== 16'h0) begin bad++; $display("FAIL midrst_err got %0h want 0", error_count); end
        total++; if (vector_count !== 16'h0) begin bad++; $display("FAIL midrst_vc got %0h want 0", vector_count); end
        repeat (3) @(negedge clk);
        total++; if ((busy | done) !== 1'b0) begin bad++; $display("FAIL midrst_idle got %0h want 0", busy | done); end
    endtask

    task automatic test_back_to_back();
        int diffs;
        run_capture(5);
        total++; if (busy_n != BUSY_EXP) begin bad++; $display("FAIL ignore_busy_cycles got %0d want %0d", busy_n, BUSY_EXP); end
        total++; if (vector_count !== 16'(NV + PRE)) begin bad++; $display("FAIL ignore_vc got %0d want %0d", vector_count, NV + PRE); end
        diffs = 0;
        for (int i = 0; i < BUSY_EXP; i++)
            if (tr_ctrl[i] !== ref_ctrl[i] || tr_pin[i] !== ref_pin[i]) diffs++;
        total++; if (diffs != 0) begin bad++; $display("FAIL ignore_trace got %0d diffs want 0", diffs); end
        run_capture(-1);
        total++; if (got_done !== 1'b1) begin bad++; $display("FAIL rerun_timeout got %0h want 1", got_done); end
        for (int i = 0; i < BUSY_EXP; i++) begin
            total++;
            if (tr_ctrl[i] !== ref_ctrl[i] || tr_pin[i] !== ref_pin[i]) begin
                bad++;
                $display("FAIL rerun_trace%0d got %0h/%0h want %0h/%0h", i, tr_ctrl[i], tr_pin[i], ref_ctrl[i], ref_pin[i]);
            end
        end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL rerun_pass got %0h want 1", pass); end
    endtask

    task automatic test_saturation();
        int guard;
        guard = 0;
        while (!done2 && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        total++; if (done2 !== 1'b1) begin bad++; $display("FAIL sat_timeout got %0h want 1", done2); end
        total++; if (error_count2 !== 16'hFFFF) begin bad++; $display("FAIL sat_err got %0h want ffff", error_count2); end
        total++; if (vector_count2 !== 16'hFFFF) begin bad++; $display("FAIL sat_vc got %0h want ffff", vector_count2); end
        total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL sat_pass got %0h want 0", pass2); end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; zero_bit0 = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        test_good_run();
`ifdef CORNER_PREAMBLE_EN
        test_preamble();
`endif
        test_bad_counter();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
